// File: rtl/pipelined_mismatch_detector_if.sv
// Sample/result bundle for pipelined_mismatch_detector.
// The master drives operands, valid and the counter clear.
// The slave (the detector) drives the result and counter outputs.
interface pipelined_mismatch_detector_if #(
  parameter int W     = 8,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic [W-1:0]     d;
  logic             cnt_clr;
  logic             out_valid;
  logic             mismatch;
  logic [W-1:0]     diff_mask;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output in_valid, a, b, c, d, cnt_clr,
    input  out_valid, mismatch, diff_mask, mismatch_cnt
  );

  modport slave (
    input  in_valid, a, b, c, d, cnt_clr,
    output out_valid, mismatch, diff_mask, mismatch_cnt
  );
endinterface

// File: rtl/pipelined_mismatch_detector.sv
// Pipelined check of (A|B) != ((B&C)^D) with a per-bit difference mask
// and a saturating mismatch counter.
// Stage 1 registers OR/AND/D, stage 2 forms the XOR, later stages only
// delay, and a final output register presents the result
// (STAGES+1 registers from input to output).
// Optional build macro SELF_STIM_EN: an internal 4*W-bit free-running
// counter supplies a/b/c/d and in_valid is held at 1.
module pipelined_mismatch_detector #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input logic                          clk,
  input logic                          rst,
  pipelined_mismatch_detector_if.slave bus
);

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_c;
  logic [W-1:0] op_d;
  logic         op_valid;

`ifdef SELF_STIM_EN
  logic [4*W-1:0] stim_cnt_reg;

  // Free-running stimulus counter; wraps naturally at 2^(4W).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stim_cnt_reg <= '0;
    else     stim_cnt_reg <= stim_cnt_reg + (4*W)'(1);
  end

  assign op_a     = stim_cnt_reg[W-1:0];
  assign op_b     = stim_cnt_reg[2*W-1:W];
  assign op_c     = stim_cnt_reg[3*W-1:2*W];
  assign op_d     = stim_cnt_reg[4*W-1:3*W];
  assign op_valid = 1'b1;
`else
  assign op_a     = bus.a;
  assign op_b     = bus.b;
  assign op_c     = bus.c;
  assign op_d     = bus.d;
  assign op_valid = bus.in_valid;
`endif

  // Stage 1 registers.
  logic [W-1:0] or1_reg;
  logic [W-1:0] and1_reg;
  logic [W-1:0] d1_reg;
  logic         v1_reg;

  // Stage 2..STAGES registers; index 2 holds the freshly formed XOR.
  logic [W-1:0] or_reg [2:STAGES];
  logic [W-1:0] x_reg  [2:STAGES];
  logic         v_reg  [2:STAGES];

  // Valid bits are reset so nothing in flight survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      v_reg[2] <= 1'b0;
    end else begin
      v1_reg   <= op_valid;
      v_reg[2] <= v1_reg;
    end
  end

  // Data registers carry no reset; bubble slots are masked at the output.
  always_ff @(posedge clk) begin
    or1_reg   <= op_a | op_b;
    and1_reg  <= op_b & op_c;
    d1_reg    <= op_d;
    or_reg[2] <= or1_reg;
    x_reg[2]  <= and1_reg ^ d1_reg;
  end

  genvar gi;
  generate
    for (gi = 3; gi <= STAGES; gi++) begin : g_delay
      // Pure delay of the valid bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) v_reg[gi] <= 1'b0;
        else     v_reg[gi] <= v_reg[gi-1];
      end

      // Pure delay of the OR and XOR operands.
      always_ff @(posedge clk) begin
        or_reg[gi] <= or_reg[gi-1];
        x_reg[gi]  <= x_reg[gi-1];
      end
    end
  endgenerate

  logic [W-1:0] tail_diff;
  logic         tail_v;
  logic         tail_hit;

  assign tail_diff = or_reg[STAGES] ^ x_reg[STAGES];
  assign tail_v    = v_reg[STAGES];
  assign tail_hit  = tail_v & (|tail_diff);

  logic             out_valid_reg;
  logic             mismatch_reg;
  logic [W-1:0]     diff_mask_reg;
  logic [CNT_W-1:0] mismatch_cnt_reg;
  logic [CNT_W-1:0] mismatch_cnt_next;

  // Counter update: clear wins, otherwise count a valid mismatch unless saturated.
  always_comb begin
    mismatch_cnt_next = mismatch_cnt_reg;
    if (bus.cnt_clr)
      mismatch_cnt_next = '0;
    else if (tail_hit && (mismatch_cnt_reg != {CNT_W{1'b1}}))
      mismatch_cnt_next = mismatch_cnt_reg + CNT_W'(1);
  end

  // Output register; results are forced to zero in bubble slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      mismatch_reg     <= 1'b0;
      diff_mask_reg    <= '0;
      mismatch_cnt_reg <= '0;
    end else begin
      out_valid_reg    <= tail_v;
      mismatch_reg     <= tail_hit;
      diff_mask_reg    <= tail_v ? tail_diff : '0;
      mismatch_cnt_reg <= mismatch_cnt_next;
    end
  end

  assign bus.out_valid    = out_valid_reg;
  assign bus.mismatch     = mismatch_reg;
  assign bus.diff_mask    = diff_mask_reg;
  assign bus.mismatch_cnt = mismatch_cnt_reg;

endmodule

// File: tb/tb_pipelined_mismatch_detector.sv
// Directed bench for pipelined_mismatch_detector (W=8, STAGES=2).
// dut_main uses CNT_W=32, dut_sat uses CNT_W=4 for saturation checks.
// With SELF_STIM_EN defined only the internal-counter sequence runs.
module tb_pipelined_mismatch_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_mismatch_detector_if #(.W(8), .CNT_W(32)) if_main ();
  pipelined_mismatch_detector_if #(.W(8), .CNT_W(4))  if_sat ();

  pipelined_mismatch_detector #(.W(8), .STAGES(2), .CNT_W(32)) dut_main (
    .clk (clk),
    .rst (rst),
    .bus (if_main.slave)
  );

  pipelined_mismatch_detector #(.W(8), .STAGES(2), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_sat.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_main(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    if_main.in_valid = v;
    if_main.a = a;
    if_main.b = b;
    if_main.c = c;
    if_main.d = d;
  endtask

  task automatic drive_sat(input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    if_sat.in_valid = v;
    if_sat.a = a;
    if_sat.b = b;
    if_sat.c = c;
    if_sat.d = d;
  endtask

  // Case-3 stream: case1, case2, bubble (case1 data, valid 0), case1, idle, idle.
  logic       s_v   [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] s_a   [0:5] = '{8'h0F, 8'h01, 8'h0F, 8'h0F, 8'h00, 8'h00};
  logic [7:0] s_b   [0:5] = '{8'hF0, 8'h02, 8'hF0, 8'hF0, 8'h00, 8'h00};
  logic [7:0] s_c   [0:5] = '{8'hFF, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0] s_d   [0:5] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic       e_ov  [0:3] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic       e_mm  [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] e_dm  [0:3] = '{8'h0F, 8'h00, 8'h00, 8'h0F};

  initial begin
    drive_main(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive_sat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    if_main.cnt_clr = 1'b0;
    if_sat.cnt_clr  = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    check_eq("reset_out_valid", 64'(if_main.out_valid), 64'd0);
    check_eq("reset_mismatch", 64'(if_main.mismatch), 64'd0);
    check_eq("reset_diff_mask", 64'(if_main.diff_mask), 64'd0);
    check_eq("reset_cnt", 64'(if_main.mismatch_cnt), 64'd0);
    rst = 1'b0;

`ifdef SELF_STIM_EN
    // Edge 1 samples counter 0; its result is visible after edge 3.
    tick();
    check_eq("ss_edge1_out_valid", 64'(if_main.out_valid), 64'd0);
    tick();
    check_eq("ss_edge2_out_valid", 64'(if_main.out_valid), 64'd0);
    tick();
    check_eq("ss_edge3_out_valid", 64'(if_main.out_valid), 64'd1);
    check_eq("ss_edge3_mismatch", 64'(if_main.mismatch), 64'd0);
    check_eq("ss_edge3_diff_mask", 64'(if_main.diff_mask), 64'd0);
    // Counter value 0x100 (b=1) is sampled at edge 257 and emerges after edge 259.
    for (int i = 0; i < 256; i++) tick();
    check_eq("ss_b1_out_valid", 64'(if_main.out_valid), 64'd1);
    check_eq("ss_b1_mismatch", 64'(if_main.mismatch), 64'd1);
    check_eq("ss_b1_diff_mask", 64'(if_main.diff_mask), 64'h01);
`else
    // Case 1: single mismatching sample, visible after the third edge.
    drive_main(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    tick();
    drive_main(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    check_eq("c1_early_out_valid", 64'(if_main.out_valid), 64'd0);
    tick();
    check_eq("c1_out_valid", 64'(if_main.out_valid), 64'd1);
    check_eq("c1_mismatch", 64'(if_main.mismatch), 64'd1);
    check_eq("c1_diff_mask", 64'(if_main.diff_mask), 64'h0F);
    check_eq("c1_cnt", 64'(if_main.mismatch_cnt), 64'd1);
    tick();
    check_eq("c1_after_out_valid", 64'(if_main.out_valid), 64'd0);

    // Case 2: matching sample.
    drive_main(1'b1, 8'h01, 8'h02, 8'h02, 8'h01);
    tick();
    drive_main(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check_eq("c2_out_valid", 64'(if_main.out_valid), 64'd1);
    check_eq("c2_mismatch", 64'(if_main.mismatch), 64'd0);
    check_eq("c2_diff_mask", 64'(if_main.diff_mask), 64'h00);
    check_eq("c2_cnt", 64'(if_main.mismatch_cnt), 64'd1);

    // Case 3: back-to-back stream with a bubble.
    for (int i = 0; i < 6; i++) begin
      drive_main(s_v[i], s_a[i], s_b[i], s_c[i], s_d[i]);
      tick();
      if (i >= 2) begin
        check_eq($sformatf("c3_out_valid[%0d]", i-2), 64'(if_main.out_valid), 64'(e_ov[i-2]));
        check_eq($sformatf("c3_mismatch[%0d]", i-2), 64'(if_main.mismatch), 64'(e_mm[i-2]));
        check_eq($sformatf("c3_diff_mask[%0d]", i-2), 64'(if_main.diff_mask), 64'(e_dm[i-2]));
      end
    end
    check_eq("c3_cnt", 64'(if_main.mismatch_cnt), 64'd3);

    // Case 5: reset while samples are in flight.
    drive_main(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    tick();
    tick();
    tick();
    check_eq("c5_pre_out_valid", 64'(if_main.out_valid), 64'd1);
    drive_main(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    check_eq("c5_async_out_valid", 64'(if_main.out_valid), 64'd0);
    check_eq("c5_async_mismatch", 64'(if_main.mismatch), 64'd0);
    check_eq("c5_async_diff_mask", 64'(if_main.diff_mask), 64'd0);
    check_eq("c5_async_cnt", 64'(if_main.mismatch_cnt), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("c5_dropped_out_valid[%0d]", i), 64'(if_main.out_valid), 64'd0);
    end
    check_eq("c5_dropped_cnt", 64'(if_main.mismatch_cnt), 64'd0);

    // Latency after reset release: STAGES+1 edges.
    drive_main(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    tick();
    drive_main(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("c5_lat_e1", 64'(if_main.out_valid), 64'd0);
    tick();
    check_eq("c5_lat_e2", 64'(if_main.out_valid), 64'd0);
    tick();
    check_eq("c5_lat_e3", 64'(if_main.out_valid), 64'd1);
    check_eq("c5_lat_cnt", 64'(if_main.mismatch_cnt), 64'd1);

    // Plain synchronous clear.
    if_main.cnt_clr = 1'b1;
    tick();
    if_main.cnt_clr = 1'b0;
    check_eq("clr_cnt", 64'(if_main.mismatch_cnt), 64'd0);

    // Case 4: saturation at 0xF with CNT_W=4.
    drive_sat(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    for (int i = 0; i < 20; i++) tick();
    drive_sat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    check_eq("c4_sat_cnt", 64'(if_sat.mismatch_cnt), 64'hF);

    // Clear on the same edge as a counted mismatch: clear wins.
    drive_sat(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    tick();
    drive_sat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    if_sat.cnt_clr = 1'b1;
    tick();
    if_sat.cnt_clr = 1'b0;
    check_eq("c4_clr_out_valid", 64'(if_sat.out_valid), 64'd1);
    check_eq("c4_clr_mismatch", 64'(if_sat.mismatch), 64'd1);
    check_eq("c4_clr_cnt", 64'(if_sat.mismatch_cnt), 64'd0);

    // Next mismatch after the clear counts normally.
    drive_sat(1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00);
    tick();
    drive_sat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check_eq("c4_post_clr_cnt", 64'(if_sat.mismatch_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
